demultiplexer4: RTL and testbench



---
 rtl/demultiplexer4.sv | 106 ++++++++++
 tb/tb_demultiplexer4.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/demultiplexer4.sv
// Buffered 1-to-4 demultiplexer with per-lane single-entry holding registers.
// Optional macro DEMULTIPLEXER4_COUNT_EN builds the per-lane delivered-word counters.
module demultiplexer4 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_bcast,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [15:0]      out_count0,
  output logic [15:0]      out_count1,
  output logic [15:0]      out_count2,
  output logic [15:0]      out_count3
);

  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [WIDTH-1:0] data_q [4];

  logic [3:0] can_load;
  logic [3:0] drain;
  logic [3:0] load;
  logic       accept;

  // A full lane whose consumer is taking its word this cycle can be refilled
  // in the same cycle, which is what gives one word per cycle per lane.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    can_load = ~valid_q | out_ready;
    drain    = valid_q & out_ready;
    in_ready = in_bcast ? (&can_load) : can_load[in_sel];
    accept   = in_valid & in_ready;
    load     = 4'b0000;
    if (accept) begin
      load = in_bcast ? 4'b1111 : (4'b0001 << in_sel);
    end
    valid_d  = load | (valid_q & ~drain);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the holding registers are reset even though they are datapath,
  // because out_data is defined to read zero after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          data_q[k] <= in_data;
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];

`ifdef DEMULTIPLEXER4_COUNT_EN
  // Counters advance on drain, so a broadcast word counts once per lane
  // as each consumer actually takes it; they wrap naturally at 16 bits.
  logic [15:0] count_q [4];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        count_q[k] <= 16'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (drain[k]) begin
          count_q[k] <= count_q[k] + 16'd1;
        end
      end
    end
  end

  assign out_count0 = count_q[0];
  assign out_count1 = count_q[1];
  assign out_count2 = count_q[2];
  assign out_count3 = count_q[3];
`else
  assign out_count0 = 16'd0;
  assign out_count1 = 16'd0;
  assign out_count2 = 16'd0;
  assign out_count3 = 16'd0;
`endif

endmodule

// File: tb/tb_demultiplexer4.sv
// Self-checking bench for demultiplexer4: directed vector table, randomized
// traffic against a lane-occupancy model, and a 16-bit counter wrap run.
module tb_demultiplexer4;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_bcast;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [15:0]      out_count0, out_count1, out_count2, out_count3;

  logic [WIDTH-1:0] od [4];
  logic [15:0]      oc [4];
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;
  assign oc[0] = out_count0;
  assign oc[1] = out_count1;
  assign oc[2] = out_count2;
  assign oc[3] = out_count3;

  demultiplexer4 #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_bcast   (in_bcast),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_data3  (out_data3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count0 (out_count0),
    .out_count1 (out_count1),
    .out_count2 (out_count2),
    .out_count3 (out_count3)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic             rst;
    logic [WIDTH-1:0] data;
    logic [1:0]       sel;
    logic             bcast;
    logic             valid;
    logic [3:0]       ordy;
    logic             exp_rdy;
    logic [3:0]       exp_ov;
    int               chk_lane;
    logic [WIDTH-1:0] chk_data;
    int               cnt_lane;
    logic [15:0]      cnt_val;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: occupancy (0 or 1 words) per lane, the last word
  // loaded into each lane, and the number of drains per lane.
  int               m_occ  [4];
  logic [WIDTH-1:0] m_last [4];
  int               m_cnt  [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_count(input int drains);
`ifdef DEMULTIPLEXER4_COUNT_EN
    return 16'(drains % 65536);
`else
    return 16'd0;
`endif
  endfunction

  function automatic vec_t mk(input logic rst, input logic [WIDTH-1:0] data, input logic [1:0] sel,
                              input logic bcast, input logic valid, input logic [3:0] ordy,
                              input logic exp_rdy, input logic [3:0] exp_ov,
                              input int chk_lane, input logic [WIDTH-1:0] chk_data,
                              input int cnt_lane, input logic [15:0] cnt_val);
    vec_t v;
    v.rst = rst; v.data = data; v.sel = sel; v.bcast = bcast; v.valid = valid; v.ordy = ordy;
    v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.chk_lane = chk_lane; v.chk_data = chk_data;
    v.cnt_lane = cnt_lane; v.cnt_val = cnt_val;
    return v;
  endfunction

  function automatic logic model_ready(input vec_t v);
    int room = 0;
    for (int k = 0; k < 4; k++) begin
      if (m_occ[k] == 0 || v.ordy[k]) room++;
    end
    if (v.bcast) return (room == 4);
    return (m_occ[v.sel] == 0 || v.ordy[v.sel]);
  endfunction

  task automatic model_compare(input vec_t v);
    logic [3:0] ov_exp;
    check("mdl_in_ready", in_ready, model_ready(v));
    for (int k = 0; k < 4; k++) ov_exp[k] = (m_occ[k] != 0);
    check("mdl_out_valid", out_valid, ov_exp);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("mdl_out_data%0d", k), od[k], m_last[k]);
      check($sformatf("mdl_out_count%0d", k), oc[k], exp_count(m_cnt[k]));
    end
  endtask

  task automatic model_update(input vec_t v);
    logic acc;
    acc = v.valid && model_ready(v);
    for (int k = 0; k < 4; k++) begin
      if (v.rst) begin
        m_occ[k] = 0; m_last[k] = '0; m_cnt[k] = 0;
      end else begin
        if (m_occ[k] != 0 && v.ordy[k]) begin
          m_occ[k] = m_occ[k] - 1;
          m_cnt[k] = m_cnt[k] + 1;
        end
        if (acc && (v.bcast || int'(v.sel) == k)) begin
          m_occ[k] = m_occ[k] + 1;
          m_last[k] = v.data;
        end
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, compare 1 time unit later,
  // then let the rising edge happen and advance the model.
  task automatic drive_cycle(input vec_t v, input logic do_tbl, input string tag, output logic rdy_seen);
    @(negedge clock);
    reset = v.rst; in_data = v.data; in_sel = v.sel; in_bcast = v.bcast;
    in_valid = v.valid; out_ready = v.ordy;
    #1;
    model_compare(v);
    if (do_tbl) begin
      check({tag, "_in_ready"}, in_ready, v.exp_rdy);
      check({tag, "_out_valid"}, out_valid, v.exp_ov);
      if (v.chk_lane >= 0) check({tag, "_out_data"}, od[v.chk_lane], v.chk_data);
      if (v.cnt_lane >= 0) check({tag, "_out_count"}, oc[v.cnt_lane], exp_count(int'(v.cnt_val)));
    end
    rdy_seen = in_ready;
    @(posedge clock);
    model_update(v);
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    logic rdy;
    logic pend;

    reset = 1'b1; in_data = '0; in_sel = 2'd0; in_bcast = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin m_occ[k] = 0; m_last[k] = '0; m_cnt[k] = 0; end
    repeat (2) @(posedge clock);

    //            rst data          sel bcast vld ordy     rdy ov       lane data          cl cnt
    vecs.push_back(mk(0, 32'hDEADBEEF, 2, 0, 1, 4'b1111, 1, 4'b0000, -1, 0,             -1, 0)); // 0 reset state, unicast
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 4'b1111, 1, 4'b0100,  2, 32'hDEADBEEF, -1, 0)); // 1
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 4'b1111, 1, 4'b0000, -1, 0,              2, 1)); // 2
    vecs.push_back(mk(0, 32'h11,       1, 0, 1, 4'b1101, 1, 4'b0000, -1, 0,             -1, 0)); // 3 fill stalled lane 1
    vecs.push_back(mk(0, 32'hA0,       0, 0, 1, 4'b1101, 1, 4'b0010,  1, 32'h11,       -1, 0)); // 4
    vecs.push_back(mk(0, 32'hA3,       3, 0, 1, 4'b1101, 1, 4'b0011,  0, 32'hA0,       -1, 0)); // 5
    vecs.push_back(mk(0, 32'h77,       1, 0, 1, 4'b1101, 0, 4'b1010,  3, 32'hA3,       -1, 0)); // 6 lane 1 blocked
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 4'b1101, 1, 4'b0010,  1, 32'h11,       -1, 0)); // 7
    vecs.push_back(mk(0, 32'h1,        0, 0, 1, 4'b1110, 1, 4'b0010,  1, 32'h11,       -1, 0)); // 8
    vecs.push_back(mk(0, 32'h2,        0, 0, 1, 4'b0001, 1, 4'b0001,  0, 32'h1,        -1, 0)); // 9 drain+refill
    vecs.push_back(mk(0, 32'h0,        1, 0, 0, 4'b0000, 1, 4'b0001,  0, 32'h2,         0, 2)); // 10
    vecs.push_back(mk(0, 32'h0,        1, 0, 0, 4'b0001, 1, 4'b0001, -1, 0,             -1, 0)); // 11
    vecs.push_back(mk(0, 32'h5A5A5A5A, 0, 1, 1, 4'b0000, 1, 4'b0000, -1, 0,             -1, 0)); // 12 broadcast
    vecs.push_back(mk(0, 32'hBBBB,     0, 1, 1, 4'b0100, 0, 4'b1111,  1, 32'h5A5A5A5A, -1, 0)); // 13 blocked
    vecs.push_back(mk(0, 32'hBBBB,     0, 1, 1, 4'b1011, 1, 4'b1011,  3, 32'h5A5A5A5A, -1, 0)); // 14
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 4'b1111, 1, 4'b1111,  2, 32'hBBBB,     -1, 0)); // 15
    vecs.push_back(mk(0, 32'hC,        0, 1, 1, 4'b0000, 1, 4'b0000, -1, 0,             -1, 0)); // 16
    vecs.push_back(mk(0, 32'h0,        2, 0, 0, 4'b0100, 1, 4'b1111, -1, 0,             -1, 0)); // 17
    vecs.push_back(mk(1, 32'hEE,       2, 0, 1, 4'b0000, 1, 4'b1011, -1, 0,             -1, 0)); // 18 reset vs accept
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 4'b0000, 1, 4'b0000,  2, 32'h0,         0, 0)); // 19

    foreach (vecs[i]) drive_cycle(vecs[i], 1'b1, $sformatf("vec%0d", i), rdy);

    // Randomized traffic; a refused offer is held unchanged until taken.
    pend = 1'b0;
    v = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, -1, 0, -1, 0);
    for (int c = 0; c < 2000; c++) begin
      v.rst  = ($urandom_range(0, 49) == 0);
      v.ordy = 4'($urandom_range(0, 15));
      if (!pend) begin
        v.valid = ($urandom_range(0, 3) != 0);
        v.data  = $urandom;
        v.sel   = 2'($urandom_range(0, 3));
        v.bcast = ($urandom_range(0, 3) == 0);
      end
      drive_cycle(v, 1'b0, "rnd", rdy);
      pend = v.valid && !rdy && !v.rst;
    end

    // Counter wrap: 65536 unicasts into lane 3, each drained one cycle later.
    v = mk(1, 0, 3, 0, 0, 4'b1000, 0, 0, -1, 0, -1, 0);
    drive_cycle(v, 1'b0, "wrap_rst", rdy);
    v.rst = 1'b0; v.valid = 1'b1;
    for (int c = 0; c < 65536; c++) begin
      v.data = c;
      drive_cycle(v, 1'b0, "wrap", rdy);
    end
    #1;
`ifdef DEMULTIPLEXER4_COUNT_EN
    check("wrap_count3_ffff", out_count3, 16'hFFFF);
`else
    check("wrap_count3_off", out_count3, 16'h0000);
`endif
    v.valid = 1'b0;
    drive_cycle(v, 1'b0, "wrap_last", rdy);
    #1;
    check("wrap_count3_zero", out_count3, 16'h0000);
    check("wrap_valid_empty", out_valid, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
